qspi_flash_read_controller: RTL and testbench
=============================================

# qspi_flash_read_controller

Sequencer that drives one QSPI host-mode transceiver to perform complete SPI NOR flash read transactions. It owns chip select, issues the command byte, the address bytes and any dummy bytes, then streams data bytes out to the requester. It supports single-bit Read (0x03) and Quad Output Fast Read (0x6B). It sits between a boot loader or memory-mapped flash window and the byte-level transceiver; it does not set the clock divider.

## Interface
- ADDR_BYTES, 3: address length in bytes (3 or 4), sent MSB first.
- DUMMY_BYTES, 1: single-mode dummy bytes after the address, quad reads only (1 byte = 8 dummy SCKs).
- CS_SETUP, 4: clk cycles from cs_n falling to the first shift_en.
- CS_HOLD, 4: clk cycles from the final shift_done to cs_n rising.
- CS_HIGH, 8: minimum clk cycles cs_n stays high before busy drops.
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  one-cycle request strobe; ignored while busy.
- rd_quad  in  1  1 = 0x6B quad read, 0 = 0x03 single read; latched with rd_en.
- rd_addr  in  32  start address; the low 8*ADDR_BYTES bits are latched with rd_en.
- rd_len  in  16  number of data bytes; latched with rd_en.
- busy  out  1  transaction in progress.
- rd_data_valid  out  1  one-cycle strobe; rd_data holds a new byte.
- rd_data  out  8  read byte, held until the next valid strobe.
- rd_done  out  1  one-cycle pulse at the end of the transaction.
- cs_n  out  1  flash chip select, active low.
- shift_en  out  1  to transceiver: start a single-bit byte shift.
- quad_shift_en  out  1  to transceiver: start a quad read byte.
- tx_data  out  8  to transceiver: byte to send, valid whenever shift_en is high.
- auto_restart  out  1  to transceiver: chain the next byte.
- shift_done  in  1  from transceiver: byte complete pulse.
- rx_data  in  8  from transceiver: received byte, valid while shift_done is high.

## Operation
- States and transitions:
  - IDLE -> SETUP on an accepted rd_en with rd_len ≠ 0.
  - SETUP -> CMD -> ADDR -> DUMMY (quad and DUMMY_BYTES>0 only) -> DATA -> HOLD -> HIGH -> IDLE.
- Zero-length request: accepted, no SPI traffic, cs_n stays 1. rd_done pulses one cycle after rd_en; busy stays 0.
- Command byte: 0x6B if rd_quad, else 0x03.
- Address bytes: sent from a shift register loaded at accept, MSB byte first.
- Dummy bytes: tx_data = 0x00.
- CMD, ADDR and DUMMY are single-bit shifts.
- Each single-bit byte: shift_en pulses for exactly one cycle, with tx_data valid in that cycle. The next byte waits for shift_done; auto_restart = 0 in these states.
- DATA phase:
  - Starts with one pulse of shift_en (single read) or quad_shift_en (quad read).
  - auto_restart is driven 1 while bytes_left > 1, where bytes_left is bytes not yet completed. The transceiver therefore chains bytes with no further start pulses.
  - On each shift_done: capture rx_data, decrement bytes_left.
  - When bytes_left reaches 0, go to HOLD.
- shift_done pulses outside CMD/ADDR/DUMMY/DATA are ignored.
- shift_en and quad_shift_en are never high in the same cycle.
- Reset values:
  - busy=0, cs_n=1, rd_data_valid=0, rd_data=0x00, rd_done=0.
  - shift_en=0, quad_shift_en=0, auto_restart=0, tx_data=0x00; state IDLE.
- Reset mid-transaction:
  - All outputs take their reset values on the next edge.
  - The transceiver finishes its current byte and stops, because auto_restart=0.
  - Its trailing shift_done is ignored.
- The bytes_left counter is 16 bits; rd_len=0xFFFF is legal and must not wrap early.

## Timing
- rd_en accepted at edge T: busy=1 and cs_n=0 from T+1.
- Command shift_en is high in cycle T+1+CS_SETUP.
- Next single-bit start pulse: the cycle after the shift_done of the previous byte.
- Data start pulse: the cycle after the last address or dummy shift_done.
- rd_data_valid: one cycle after each DATA shift_done (registered).
- Last data shift_done at cycle D:
  - rd_data_valid at D+1.
  - cs_n=1 from D+1+CS_HOLD.
  - rd_done=1 and busy=0 at D+1+CS_HOLD+CS_HIGH.
- Throughput: limited only by the transceiver during DATA; there is no inter-byte gap beyond its own restart.

## Test plan
- Single read, rd_addr=0x123456, rd_len=2, model returns 0xA5,0x3C:
  - tx byte order 0x03,0x12,0x34,0x56.
  - Two rd_data_valid strobes carrying 0xA5 then 0x3C.
  - One rd_done; cs_n low for the whole transaction.
- Quad read, addr=0x000100, rd_len=4:
  - Bytes 0x6B,0x00,0x01,0x00,0x00 sent single-bit.
  - One quad_shift_en; auto_restart high for the first 3 data shift_dones and low at the 4th.
  - 4 valid strobes.
- rd_len=0: no shift_en and cs_n stays 1; rd_done exactly 1 cycle after rd_en.
- rd_en pulsed mid-transaction with a different address: ignored; the original transaction completes unchanged.
- rst asserted during the ADDR phase:
  - Next cycle cs_n=1, busy=0, all strobes 0.
  - A stray shift_done produces no rd_data_valid.
  - A new read afterwards completes correctly.
- Timing check with CS_SETUP=4, CS_HOLD=4, CS_HIGH=8: measure exact cycle distances rd_en→shift_en, last shift_done→cs_n rise, and cs_n rise→rd_done.

Source files
------------

// File: rtl/qspi_flash_read_controller.sv
// Sequences one QSPI transceiver through a full SPI NOR read: chip select,
// command, address, optional dummy bytes, then a chained data stream.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   rd_en/rd_quad/rd_addr/rd_len      - request (latched on accept)
//   busy, rd_data_valid, rd_data      - requester side status and data
//   rd_done                           - end-of-transaction pulse
//   cs_n, shift_en, quad_shift_en     - transceiver control
//   tx_data, auto_restart             - transceiver byte and chaining
//   shift_done, rx_data               - transceiver completion and data
module qspi_flash_read_controller #(
   parameter int ADDR_BYTES  = 3,
   parameter int DUMMY_BYTES = 1,
   parameter int CS_SETUP    = 4,
   parameter int CS_HOLD     = 4,
   parameter int CS_HIGH     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        rd_quad,
   input  logic [31:0] rd_addr,
   input  logic [15:0] rd_len,
   output logic        busy,
   output logic        rd_data_valid,
   output logic [7:0]  rd_data,
   output logic        rd_done,
   output logic        cs_n,
   output logic        shift_en,
   output logic        quad_shift_en,
   output logic [7:0]  tx_data,
   output logic        auto_restart,
   input  logic        shift_done,
   input  logic [7:0]  rx_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_CMD, S_ADDR,
      S_DUMMY, S_DATA, S_HOLD, S_HIGH
   } state_t;

   // Left-align the address so the next byte to send is always [31:24].
   localparam int ASHIFT = 32 - 8 * ADDR_BYTES;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] left_q, left_d;
   logic [31:0] addr_q, addr_d;
   logic        quad_q, quad_d;
   logic        busy_q, busy_d;
   logic        cs_n_q, cs_n_d;
   logic        vld_q, vld_d;
   logic [7:0]  rdat_q, rdat_d;
   logic        done_q, done_d;
   logic        sh_q, sh_d;
   logic        qsh_q, qsh_d;
   logic [7:0]  tx_q, tx_d;
   logic        ar_q, ar_d;
   logic        go_data;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      addr_d  = addr_q;
      quad_d  = quad_q;
      busy_d  = busy_q;
      cs_n_d  = cs_n_q;
      vld_d   = 1'b0;
      rdat_d  = rdat_q;
      done_d  = 1'b0;
      sh_d    = 1'b0;
      qsh_d   = 1'b0;
      tx_d    = tx_q;
      ar_d    = ar_q;
      go_data = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (rd_en) begin
               if (rd_len == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_SETUP;
                  busy_d  = 1'b1;
                  cs_n_d  = 1'b0;
                  cnt_d   = 16'd0;
                  addr_d  = rd_addr << ASHIFT;
                  quad_d  = rd_quad;
                  left_d  = rd_len;
               end
            end
         end
         S_SETUP: begin
            if (cnt_q == 16'(CS_SETUP - 1)) begin
               state_d = S_CMD;
               sh_d    = 1'b1;
               tx_d    = quad_q ? 8'h6B : 8'h03;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_CMD: begin
            if (shift_done) begin
               state_d = S_ADDR;
               sh_d    = 1'b1;
               tx_d    = addr_q[31:24];
               addr_d  = addr_q << 8;
               cnt_d   = 16'(ADDR_BYTES - 1);
            end
         end
         // cnt_q holds how many bytes of the phase are still unsent.
         S_ADDR: begin
            if (shift_done) begin
               if (cnt_q != 16'd0) begin
                  sh_d   = 1'b1;
                  tx_d   = addr_q[31:24];
                  addr_d = addr_q << 8;
                  cnt_d  = cnt_q - 16'd1;
               end else if (quad_q && DUMMY_BYTES > 0) begin
                  state_d = S_DUMMY;
                  sh_d    = 1'b1;
                  tx_d    = 8'h00;
                  cnt_d   = 16'(DUMMY_BYTES - 1);
               end else begin
                  go_data = 1'b1;
               end
            end
         end
         S_DUMMY: begin
            if (shift_done) begin
               if (cnt_q != 16'd0) begin
                  sh_d  = 1'b1;
                  tx_d  = 8'h00;
                  cnt_d = cnt_q - 16'd1;
               end else begin
                  go_data = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (shift_done) begin
               vld_d  = 1'b1;
               rdat_d = rx_data;
               left_d = left_q - 16'd1;
               // Keep chaining while more than one byte remains after this.
               ar_d   = (left_q > 16'd2);
               if (left_q == 16'd1) begin
                  state_d = S_HOLD;
                  cnt_d   = 16'd0;
               end
            end
         end
         S_HOLD: begin
            if (cnt_q == 16'(CS_HOLD - 1)) begin
               state_d = S_HIGH;
               cs_n_d  = 1'b1;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_HIGH: begin
            if (cnt_q == 16'(CS_HIGH - 1)) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (go_data) begin
         state_d = S_DATA;
         sh_d    = ~quad_q;
         qsh_d   = quad_q;
         tx_d    = 8'h00;
         ar_d    = (left_q > 16'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         left_q  <= 16'd0;
         addr_q  <= 32'd0;
         quad_q  <= 1'b0;
         busy_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         vld_q   <= 1'b0;
         rdat_q  <= 8'h00;
         done_q  <= 1'b0;
         sh_q    <= 1'b0;
         qsh_q   <= 1'b0;
         tx_q    <= 8'h00;
         ar_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
         addr_q  <= addr_d;
         quad_q  <= quad_d;
         busy_q  <= busy_d;
         cs_n_q  <= cs_n_d;
         vld_q   <= vld_d;
         rdat_q  <= rdat_d;
         done_q  <= done_d;
         sh_q    <= sh_d;
         qsh_q   <= qsh_d;
         tx_q    <= tx_d;
         ar_q    <= ar_d;
      end
   end

   assign busy          = busy_q;
   assign cs_n          = cs_n_q;
   assign rd_data_valid = vld_q;
   assign rd_data       = rdat_q;
   assign rd_done       = done_q;
   assign shift_en      = sh_q;
   assign quad_shift_en = qsh_q;
   assign tx_data       = tx_q;
   assign auto_restart  = ar_q;

endmodule

// File: tb/tb_qspi_flash_read_controller.sv
// Bench for qspi_flash_read_controller: transceiver + flash model,
// directed and randomized reads, timing and reset scenarios.
`timescale 1ns/1ps
module tb_qspi_flash_read_controller;

   localparam int AB  = 3;
   localparam int DB  = 1;
   localparam int CSS = 4;
   localparam int CSH = 4;
   localparam int CSI = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0;
   logic        rd_quad = 1'b0;
   logic [31:0] rd_addr = 32'd0;
   logic [15:0] rd_len = 16'd0;
   logic        busy, rd_data_valid, rd_done, cs_n;
   logic        shift_en, quad_shift_en, auto_restart;
   logic [7:0]  rd_data, tx_data;
   logic        shift_done = 1'b0;
   logic [7:0]  rx_data = 8'h00;

   int checks = 0;
   int errors = 0;

   qspi_flash_read_controller #(
      .ADDR_BYTES(AB), .DUMMY_BYTES(DB),
      .CS_SETUP(CSS), .CS_HOLD(CSH), .CS_HIGH(CSI)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_en(rd_en), .rd_quad(rd_quad),
      .rd_addr(rd_addr), .rd_len(rd_len),
      .busy(busy), .rd_data_valid(rd_data_valid),
      .rd_data(rd_data), .rd_done(rd_done),
      .cs_n(cs_n), .shift_en(shift_en),
      .quad_shift_en(quad_shift_en), .tx_data(tx_data),
      .auto_restart(auto_restart),
      .shift_done(shift_done), .rx_data(rx_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state and observation logs
   logic [7:0] tx_log[$];
   logic [7:0] got[$];
   logic [7:0] fbytes[$];
   logic [7:0] exp_hdr[$];
   bit         ar_log[$];
   int hdr = 0, fidx = 0, xlat = 2, x_cnt = 0;
   bit x_act = 1'b0;
   int nquad, ndone, nbusy, ncs_fall, ncs_rise;
   int first_sh_cyc, last_done_cyc, cs_rise_cyc, cs_fall_cyc, done_cyc;
   int both_err = 0, cs_err = 0, overlap_err = 0;
   int en_cyc = 0;
   bit busy_at_done = 1'b0;
   bit cs_prev = 1'b1;

   // Transceiver and SPI flash behaviour, plus output monitor.
   always @(negedge clk) begin
      shift_done = 1'b0;
      if (x_act) begin
         if (x_cnt == 0) begin
            shift_done = 1'b1;
            if (!cs_n && fidx >= hdr && (fidx - hdr) < int'(fbytes.size()))
               rx_data = fbytes[fidx - hdr];
            else
               rx_data = 8'hFF;
            fidx++;
            if (!cs_n) last_done_cyc = cyc;
            ar_log.push_back(auto_restart);
            if (auto_restart) x_cnt = xlat;
            else x_act = 1'b0;
         end else begin
            x_cnt--;
         end
      end
      if (shift_en && quad_shift_en) both_err++;
      if (shift_en || quad_shift_en) begin
         if (x_act) overlap_err++;
         if (cs_n) cs_err++;
         x_act = 1'b1;
         x_cnt = xlat;
         if (shift_en) tx_log.push_back(tx_data);
         else nquad++;
         if (first_sh_cyc < 0) first_sh_cyc = cyc;
      end
      if (rd_data_valid) got.push_back(rd_data);
      if (rd_done) begin
         ndone++;
         done_cyc = cyc;
         busy_at_done = busy;
      end
      if (busy) nbusy++;
      if (cs_n && !cs_prev) begin ncs_rise++; cs_rise_cyc = cyc; end
      if (!cs_n && cs_prev) begin ncs_fall++; cs_fall_cyc = cyc; end
      cs_prev = cs_n;
   end

   task automatic prep(input bit q, input logic [31:0] a,
                       input int len, input bit rnd);
      exp_hdr.delete();
      exp_hdr.push_back(q ? 8'h6B : 8'h03);
      for (int i = AB - 1; i >= 0; i--) exp_hdr.push_back(a[8*i +: 8]);
      if (q) for (int i = 0; i < DB; i++) exp_hdr.push_back(8'h00);
      hdr = exp_hdr.size();
      if (rnd) begin
         fbytes.delete();
         for (int i = 0; i < len; i++) fbytes.push_back(8'($urandom));
      end
      tx_log.delete(); got.delete(); ar_log.delete();
      fidx = 0; nquad = 0; ndone = 0; nbusy = 0;
      ncs_fall = 0; ncs_rise = 0;
      first_sh_cyc = -1; last_done_cyc = -1; cs_rise_cyc = -1;
      cs_fall_cyc = -1; done_cyc = -1;
   endtask

   task automatic pulse_rd(input bit q, input logic [31:0] a,
                           input logic [15:0] len);
      @(negedge clk);
      rd_en = 1'b1; rd_quad = q; rd_addr = a; rd_len = len;
      en_cyc = cyc;
      @(negedge clk);
      rd_en = 1'b0;
      rd_quad = 1'($urandom); rd_addr = $urandom; rd_len = 16'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (ndone == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ndone == 0) begin
         errors++;
         $display("FAIL timeout: no rd_done, need one within %0d cycles", budget);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; rd_en = 1'b1; rd_len = 16'd5;
      repeat (3) @(negedge clk);
      rd_en = 1'b0;
      checks++;
      if ({busy, cs_n, rd_data_valid, rd_done, shift_en, quad_shift_en, auto_restart}
          !== 7'b0100000) begin
         errors++;
         $display("FAIL reset_ctl: got %b need 0100000",
            {busy, cs_n, rd_data_valid, rd_done, shift_en, quad_shift_en, auto_restart});
      end
      checks++;
      if (rd_data !== 8'h00) begin
         errors++; $display("FAIL reset_rd_data: got %h need 00", rd_data);
      end
      checks++;
      if (tx_data !== 8'h00) begin
         errors++; $display("FAIL reset_tx_data: got %h need 00", tx_data);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single_read;
      int bad;
      xlat = 3;
      fbytes.delete();
      fbytes.push_back(8'hA5);
      fbytes.push_back(8'h3C);
      prep(1'b0, 32'h0012_3456, 2, 1'b0);
      pulse_rd(1'b0, 32'h0012_3456, 16'd2);
      wait_done(2000);
      bad = 0;
      if (tx_log.size() != 5) bad++;
      else for (int i = 0; i < 4; i++) if (tx_log[i] !== exp_hdr[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL single_tx: got %0d starts (%0d wrong), need 5 with 03 12 34 56",
            tx_log.size(), bad);
      end
      checks++;
      if (got.size() != 2 || got[0] !== 8'hA5 || got[1] !== 8'h3C) begin
         errors++;
         $display("FAIL single_data: got %0d bytes, need A5 3C", got.size());
      end
      checks++;
      if (ndone != 1 || nquad != 0 || ncs_fall != 1 || ncs_rise != 1 || cs_err != 0) begin
         errors++;
         $display("FAIL single_ctl: done=%0d quad=%0d fall=%0d rise=%0d cserr=%0d need 1 0 1 1 0",
            ndone, nquad, ncs_fall, ncs_rise, cs_err);
      end
      checks++;
      if (cs_fall_cyc - en_cyc != 1 || first_sh_cyc - en_cyc != 1 + CSS) begin
         errors++;
         $display("FAIL t_setup: cs fall %0d shift_en %0d after rd_en, need 1 and %0d",
            cs_fall_cyc - en_cyc, first_sh_cyc - en_cyc, 1 + CSS);
      end
      checks++;
      if (cs_rise_cyc - last_done_cyc != 1 + CSH) begin
         errors++;
         $display("FAIL t_hold: got %0d need %0d", cs_rise_cyc - last_done_cyc, 1 + CSH);
      end
      checks++;
      if (done_cyc - cs_rise_cyc != CSI || busy_at_done !== 1'b0) begin
         errors++;
         $display("FAIL t_high: got %0d busy=%b need %0d busy=0",
            done_cyc - cs_rise_cyc, busy_at_done, CSI);
      end
   endtask

   task automatic test_quad_read;
      int bad;
      xlat = 2;
      prep(1'b1, 32'h0000_0100, 4, 1'b1);
      pulse_rd(1'b1, 32'h0000_0100, 16'd4);
      wait_done(2000);
      bad = 0;
      if (tx_log.size() != 5) bad++;
      else for (int i = 0; i < 5; i++) if (tx_log[i] !== exp_hdr[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL quad_tx: got %0d single starts (%0d wrong), need 6B 00 01 00 00",
            tx_log.size(), bad);
      end
      checks++;
      if (nquad != 1) begin
         errors++; $display("FAIL quad_start: got %0d quad_shift_en, need 1", nquad);
      end
      bad = 0;
      if (ar_log.size() != 9) bad++;
      else for (int k = 0; k < 4; k++) if (ar_log[5 + k] !== (k < 3)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL quad_autorestart: %0d dones %0d wrong, need 9 with data 1110",
            ar_log.size(), bad);
      end
      bad = 0;
      if (got.size() != 4) bad++;
      else foreach (got[k]) if (got[k] !== fbytes[k]) bad++;
      checks++;
      if (bad != 0 || ndone != 1) begin
         errors++;
         $display("FAIL quad_data: got %0d bytes %0d wrong done=%0d, need 4 bytes done=1",
            got.size(), bad, ndone);
      end
   endtask

   task automatic test_zero_len;
      prep(1'b0, $urandom, 0, 1'b1);
      pulse_rd(1'b0, $urandom, 16'd0);
      repeat (20) @(negedge clk);
      checks++;
      if (ndone != 1 || done_cyc - en_cyc != 1) begin
         errors++;
         $display("FAIL zero_done: got %0d pulses at +%0d, need 1 at +1",
            ndone, done_cyc - en_cyc);
      end
      checks++;
      if (tx_log.size() != 0 || nquad != 0 || ncs_fall != 0 || nbusy != 0) begin
         errors++;
         $display("FAIL zero_quiet: sh=%0d q=%0d csfall=%0d busy=%0d, need all 0",
            tx_log.size(), nquad, ncs_fall, nbusy);
      end
   endtask

   task automatic test_ignore_rd_en;
      int bad;
      logic [31:0] a;
      a = $urandom;
      xlat = 2;
      prep(1'b0, a, 6, 1'b1);
      pulse_rd(1'b0, a, 16'd6);
      repeat (2) @(negedge clk);
      rd_en = 1'b1; rd_quad = 1'b1; rd_addr = ~a; rd_len = 16'd3;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (36) @(negedge clk);
      rd_en = 1'b1; rd_quad = 1'b1; rd_addr = a ^ 32'h00F0F0F0; rd_len = 16'd0;
      @(negedge clk);
      rd_en = 1'b0;
      wait_done(2000);
      bad = 0;
      if (tx_log.size() != 5) bad++;
      else for (int i = 0; i < 4; i++) if (tx_log[i] !== exp_hdr[i]) bad++;
      if (got.size() != 6) bad++;
      else foreach (got[k]) if (got[k] !== fbytes[k]) bad++;
      checks++;
      if (bad != 0 || ndone != 1 || nquad != 0) begin
         errors++;
         $display("FAIL ignore_rd_en: %0d wrong, done=%0d quad=%0d, need 0 wrong done=1 quad=0",
            bad, ndone, nquad);
      end
   endtask

   task automatic test_reset_mid;
      int n, sh0, bad;
      xlat = 4;
      prep(1'b0, $urandom, 8, 1'b1);
      pulse_rd(1'b0, $urandom, 16'd8);
      n = 0;
      while (tx_log.size() < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (tx_log.size() < 2) begin
         errors++;
         $display("FAIL rst_mid_reach: got %0d starts, need 2 before ADDR reset", tx_log.size());
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({cs_n, busy, rd_data_valid, rd_done, shift_en, quad_shift_en, auto_restart}
          !== 7'b1000000) begin
         errors++;
         $display("FAIL rst_mid_out: got %b need 1000000",
            {cs_n, busy, rd_data_valid, rd_done, shift_en, quad_shift_en, auto_restart});
      end
      sh0 = tx_log.size();
      n = 0;
      while (x_act && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (6) @(negedge clk);
      checks++;
      if (got.size() != 0 || tx_log.size() != sh0 || ndone != 0 || cs_n !== 1'b1
          || x_act) begin
         errors++;
         $display("FAIL rst_mid_stray: valid=%0d newsh=%0d done=%0d cs_n=%b, need 0 0 0 1",
            got.size(), tx_log.size() - sh0, ndone, cs_n);
      end
      prep(1'b1, 32'h00AB_CDEF, 5, 1'b1);
      pulse_rd(1'b1, 32'h00AB_CDEF, 16'd5);
      wait_done(2000);
      bad = 0;
      if (tx_log.size() != hdr) bad++;
      else for (int i = 0; i < hdr; i++) if (tx_log[i] !== exp_hdr[i]) bad++;
      if (got.size() != 5) bad++;
      else foreach (got[k]) if (got[k] !== fbytes[k]) bad++;
      checks++;
      if (bad != 0 || ndone != 1) begin
         errors++;
         $display("FAIL rst_mid_after: %0d wrong done=%0d, need 0 wrong done=1", bad, ndone);
      end
   endtask

   task automatic test_random;
      int bad, len;
      bit q;
      logic [31:0] a;
      for (int it = 0; it < 10; it++) begin
         q = 1'($urandom_range(0, 1));
         a = $urandom;
         len = (it == 9) ? 257 + $urandom_range(0, 40) : $urandom_range(1, 24);
         xlat = $urandom_range(1, 6);
         prep(q, a, len, 1'b1);
         pulse_rd(q, a, 16'(len));
         wait_done(5000);
         bad = 0;
         if (tx_log.size() != hdr + (q ? 0 : 1)) bad++;
         else for (int i = 0; i < hdr; i++) if (tx_log[i] !== exp_hdr[i]) bad++;
         if (nquad != (q ? 1 : 0)) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL rand_hdr it%0d: %0d starts q=%0d, need %0d header bytes quad=%0d",
               it, tx_log.size(), nquad, hdr, q);
         end
         bad = 0;
         if (got.size() != len) bad++;
         else foreach (got[k]) if (got[k] !== fbytes[k]) bad++;
         checks++;
         if (bad != 0 || ndone != 1) begin
            errors++;
            $display("FAIL rand_data it%0d: %0d bytes %0d wrong done=%0d, need %0d done=1",
               it, got.size(), bad, ndone, len);
         end
         bad = 0;
         if (ar_log.size() != hdr + len) bad++;
         else for (int k = 0; k < len; k++) if (ar_log[hdr + k] !== (k < len - 1)) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL rand_autorestart it%0d: %0d dones %0d wrong, need %0d",
               it, ar_log.size(), bad, hdr + len);
         end
         checks++;
         if (first_sh_cyc - en_cyc != 1 + CSS || cs_rise_cyc - last_done_cyc != 1 + CSH
             || done_cyc - cs_rise_cyc != CSI) begin
            errors++;
            $display("FAIL rand_timing it%0d: got %0d/%0d/%0d need %0d/%0d/%0d", it,
               first_sh_cyc - en_cyc, cs_rise_cyc - last_done_cyc,
               done_cyc - cs_rise_cyc, 1 + CSS, 1 + CSH, CSI);
         end
      end
   endtask

   initial begin
      test_reset;
      test_single_read;
      test_quad_read;
      test_zero_len;
      test_ignore_rd_en;
      test_reset_mid;
      test_random;
      checks++;
      if (both_err != 0 || overlap_err != 0) begin
         errors++;
         $display("FAIL strobe_overlap: both=%0d early_start=%0d, need 0 0",
            both_err, overlap_err);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
